// File: rtl/rv32i_dmem_responder.sv
// Single-outstanding RV32I data-memory responder with byte-lane writes and a fixed response latency.
// Optional request checking (address range, byte-enable pattern) is enabled by defining DMEM_ERR_CHECK_EN.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// WAIT  | request captured, latency counter running
// RESP  | response held until rsp_ready
module rv32i_dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  logic [31:0]   mem [DEPTH_WORDS];
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_ready_d, rsp_valid_d, rsp_err_d;
  logic [31:0]   rsp_rdata_d;
  logic          we_q, err_q;
  logic [AW-1:0] idx_q;
  logic [AW-1:0] req_idx;
  logic          accept, req_err;

  assign req_idx = req_addr[2 +: AW];
  assign accept  = req_valid && req_ready;

`ifdef DMEM_ERR_CHECK_EN
  logic       be_legal;
  logic [1:0] unused_addr_lsb;

  always_comb begin
    case (req_be)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
      default:                   be_legal = 1'b0;
    endcase
  end

  assign req_err         = (|req_addr[31:AW+2]) || !be_legal;
  assign unused_addr_lsb = req_addr[1:0];
`else
  logic [31-AW:0] unused_addr;

  // Upper address bits are dropped so out-of-range addresses wrap.
  assign req_err     = 1'b0;
  assign unused_addr = {req_addr[31:AW+2], req_addr[1:0]};
`endif

  // Array is deliberately not reset; writes commit at the accept edge.
  always_ff @(posedge clk) begin
    if (accept && req_we && !req_err) begin
      for (int k = 0; k < 4; k++) begin
        if (req_be[k]) mem[req_idx][8*k +: 8] <= req_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      if (accept) begin
        we_q  <= req_we;
        err_q <= req_err;
        idx_q <= req_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    req_ready_d = (state_d == IDLE);
    case (state_q)
      IDLE: if (accept) cnt_d = CW'(LATENCY - 1);
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_q;
          rsp_rdata_d = (we_q || err_q) ? 32'h0 : mem[idx_q];
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b0;
        end
      end
      default: cnt_d = '0;
    endcase
  end

endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// Scoreboard bench for rv32i_dmem_responder: a word-array reference model predicts each response,
// a negedge monitor checks data, error flag, latency and hold stability.
module tb_rv32i_dmem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk, reset_n;
  logic        req_valid, req_ready, req_we;
  logic [3:0]  req_be;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  rv32i_dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [DEPTH];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  function automatic logic model_err(input logic [3:0] be, input logic [31:0] addr);
`ifdef DMEM_ERR_CHECK_EN
    return (addr >= 32'(4 * DEPTH)) ||
           (be != 4'b0000 && !(be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                          4'b0011, 4'b1100, 4'b1111}));
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: pops one expectation per rising rsp_valid, then checks the held response stays put.
  logic        active = 1'b0;
  logic [31:0] cur_rdata;
  logic        cur_err;
  always @(negedge clk) begin
    if (reset_n && rsp_valid) begin
      if (!active) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp_valid", 32'(rsp_valid), 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("rsp_latency", 32'(cyc - e.acc), 32'(LAT));
        end
        active    = 1'b1;
        cur_rdata = rsp_rdata;
        cur_err   = rsp_err;
      end else begin
        chk("hold_rdata", rsp_rdata, cur_rdata);
        chk("hold_err", 32'(rsp_err), 32'(cur_err));
      end
      chk("req_ready_during_rsp", 32'(req_ready), 32'h0);
    end else begin
      active = 1'b0;
    end
  end

  task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata, input int hold);
    int   n;
    int   w;
    exp_t e;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    if (!req_ready) begin fail_now("req_ready_wait"); return; end
    req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = wdata;
    w       = int'((addr >> 2) % DEPTH);
    e.err   = model_err(be, addr);
    e.acc   = cyc + 1;
    e.rdata = (we || e.err) ? 32'h0 : model[w];
    if (we && !e.err)
      for (int k = 0; k < 4; k++) if (be[k]) model[w][8*k +: 8] = wdata[8*k +: 8];
    sb.push_back(e);
    @(negedge clk);
    chk("req_ready_after_accept", 32'(req_ready), 32'h0);
    // Garbage on the request bus while busy must be ignored.
    req_valid = 1'(($urandom_range(0, 1)));
    req_we    = 1'b1;
    req_be    = 4'hF;
    req_addr  = 32'($urandom_range(0, 31)) << 2;
    req_wdata = $urandom;
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    if (!rsp_valid) begin fail_now("rsp_valid_wait"); req_valid = 1'b0; return; end
    repeat (hold) begin
      @(negedge clk);
      chk("req_ready_while_held", 32'(req_ready), 32'h0);
      chk("rsp_valid_while_held", 32'(rsp_valid), 32'h1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("rsp_valid_after_hs", 32'(rsp_valid), 32'h0);
    chk("req_ready_after_hs", 32'(req_ready), 32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_be = 4'h0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_rsp_err", 32'(rsp_err), 32'h0);
    reset_n = 1'b1;
    #1 chk("req_ready_before_first_edge", 32'(req_ready), 32'h0);
    @(negedge clk);
    chk("req_ready_first_edge", 32'(req_ready), 32'h1);

    for (int i = 0; i < 32; i++) issue(1'b1, 4'hF, 32'(i * 4), $urandom, 0);

    issue(1'b1, 4'hF, 32'h0C, 32'h12345678, 0);
    issue(1'b0, 4'hF, 32'h0C, 32'h0, 1);

    issue(1'b1, 4'hF, 32'h50, 32'h0, 0);
    issue(1'b1, 4'h1, 32'h50, 32'h80, 0);
    issue(1'b1, 4'h2, 32'h50, 32'h9100, 2);
    issue(1'b0, 4'hF, 32'h50, 32'h0, 0);

    issue(1'b0, 4'hF, 32'h0C, 32'h0, 3);

    issue(1'b1, 4'hF, 32'h400, 32'hCAFEF00D, 0);
    issue(1'b1, 4'h6, 32'h50, 32'hFFFFFFFF, 0);
    issue(1'b0, 4'hF, 32'h50, 32'h0, 0);
    issue(1'b0, 4'hF, 32'h00, 32'h0, 0);
    issue(1'b1, 4'h0, 32'h0C, 32'hFFFFFFFF, 0);
    issue(1'b0, 4'hF, 32'h0C, 32'h0, 0);

    // Reset pulse while a read sits in WAIT: the response must never appear.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_be = 4'hF; req_addr = 32'h0C;
    @(negedge clk);
    req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_wait_req_ready", 32'(req_ready), 32'h0);
    chk("rst_wait_rsp_valid", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    chk("rst_hold_req_ready", 32'(req_ready), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_release_req_ready", 32'(req_ready), 32'h1);
    repeat (6) @(negedge clk);
    issue(1'b0, 4'hF, 32'h0C, 32'h0, 0);

    for (int i = 0; i < 80; i++)
      issue(1'(($urandom_range(0, 1))), 4'($urandom_range(0, 15)),
            32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3)),
            $urandom, int'($urandom_range(0, 3)));

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_dmem_responder.md
RV32I_DMEM_RESPONDER -- requirements
Module: rv32i_dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, giving the number of 32-bit words (power of two, at least 4).
REQ-002 SHALL have parameter LATENCY, default 2, giving the number of cycles from request accept to response (at least 1).
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, 1 bit: requester presents a request.
REQ-006 SHALL have port req_ready, output, 1 bit: responder can accept a request.
REQ-007 SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port req_be, input, 4 bits: byte-lane enables, lane k = bits [8k+7:8k].
REQ-009 SHALL have port req_addr, input, 32 bits: byte address; word index = req_addr[2 +: log2(DEPTH_WORDS)].
REQ-010 SHALL have port req_wdata, input, 32 bits: write data, already lane-aligned by the requester.
REQ-011 SHALL have port rsp_valid, output, 1 bit: response present.
REQ-012 SHALL have port rsp_ready, input, 1 bit: requester accepts the response.
REQ-013 SHALL have port rsp_rdata, output, 32 bits: full unshifted word for reads; 0 for writes and errors.
REQ-014 SHALL have port rsp_err, output, 1 bit: request rejected (see Configuration).

Function
REQ-015 SHALL use states IDLE, WAIT and RESP, with at most one request outstanding.
REQ-016 SHALL register req_ready, driving it 1 only in IDLE.
REQ-017 SHALL accept a request at the edge where req_valid && req_ready, then capture we/be/addr/wdata, clear req_ready, load the counter with LATENCY-1 and enter WAIT.
REQ-018 SHALL commit an accepted, error-free write at the accept edge, writing only the lanes whose req_be bit is 1; other lanes are unchanged.
REQ-019 In WAIT, SHALL decrement the counter while it is nonzero; when it is 0, SHALL enter RESP on the next edge, registering rsp_rdata, rsp_err and rsp_valid=1.
REQ-020 SHALL make rsp_valid first observable exactly LATENCY edges after the accept edge.
REQ-021 SHALL take read data from the array at the WAIT-to-RESP edge, so it reflects every earlier committed write.
REQ-022 In RESP, SHALL hold rsp_valid, rsp_rdata and rsp_err stable while rsp_ready=0.
REQ-023 At the edge where rsp_valid && rsp_ready, SHALL clear rsp_valid, rsp_rdata and rsp_err, set req_ready=1 and enter IDLE.
REQ-024 SHALL accept a new request no earlier than the edge after the response handshake, with no same-cycle turnaround.
REQ-025 SHALL ignore req_* inputs while req_ready=0 and treat req_be=0000 on a write as a no-op write with a normal response.

Reset
REQ-026 While reset_n=0, SHALL force state=IDLE, counter=0, req_ready=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0.
REQ-027 SHALL set req_ready=1 at the first rising edge after reset_n deasserts.
REQ-028 SHALL handle reset during WAIT or RESP by dropping the pending response, with no rsp_valid afterwards.
REQ-029 SHALL keep a write already committed before reset in the array, and SHALL NOT reset array contents.

Configuration
REQ-030 With macro DMEM_ERR_CHECK_EN defined, SHALL flag an error if req_addr >= 4*DEPTH_WORDS.
REQ-031 With DMEM_ERR_CHECK_EN defined, SHALL also flag an error if req_be is nonzero and not one of 0001, 0010, 0100, 1000, 0011, 1100 or 1111.
REQ-032 With DMEM_ERR_CHECK_EN defined, an errored request SHALL suppress the write and return rsp_err=1 and rsp_rdata=0 with normal latency.
REQ-033 Without DMEM_ERR_CHECK_EN, SHALL tie rsp_err to 0, wrap the address modulo DEPTH_WORDS, and honour any req_be pattern.

Verification
REQ-034 Bench SHALL cover: write addr 0x0C, be 1111, wdata 0x12345678, then read 0x0C -> rsp_rdata=0x12345678, rsp_err=0, rsp_valid exactly 2 edges after each accept.
REQ-035 Bench SHALL cover: write addr 0x50, be 0001, wdata 0x80; then write 0x50, be 0010, wdata 0x9100; then read 0x50 -> rsp_rdata=0x00009180, with bytes 3:2 keeping prior contents (0 after a prior full-word write of 0).
REQ-036 Bench SHALL cover: read response with rsp_ready held 0 for 3 cycles -> rsp_valid/rsp_rdata stable and req_ready=0 throughout; handshake -> req_ready=1 on the next edge.
REQ-037 Bench SHALL cover, with DMEM_ERR_CHECK_EN: write addr 0x400, be 1111 -> rsp_err=1; then write be 0110 at 0x50 -> rsp_err=1, and a read of 0x50 is unchanged; without the macro, a 0x400 write aliases to word 0.
REQ-038 Bench SHALL cover: reset_n pulsed low during WAIT of a read -> no rsp_valid, req_ready=0 during reset and 1 on the first edge after release, and a subsequent read is correct.
